// File: rtl/pwm_meas_pkg.sv
// Shared FSM encodings, default parameters and record field widths for the PWM measurement
// scheduler.
package pwm_meas_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEAS_HIGH = 3'd3;
  localparam logic [2:0] ST_MEAS_LOW  = 3'd4;
  localparam logic [2:0] ST_REPORT    = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;

  localparam int unsigned N_CH_DEF    = 8;
  localparam int unsigned CNT_W_DEF   = 24;
  localparam int unsigned TIMEOUT_DEF = 10_000_000;
  localparam int unsigned SETTLE_DEF  = 4;

  // Width of the result_ch / sel_ch fields.
  function automatic int unsigned ch_w(int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// One-bit 2-FF synchronizer followed by a delay flop; exposes synced level and edge strobes.
module pwm_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_dly;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_meas_scheduler.sv
// Round-robin duty/period measurement engine shared across N_CH PWM inputs.
// Optional sticky alive/stuck status flops are built when PWM_MEAS_STATUS_EN is defined.
module pwm_meas_scheduler
  import pwm_meas_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned SETTLE  = SETTLE_DEF
) (
  input  logic                      CLK100MHZ,
  input  logic                      reset,
  input  logic [N_CH-1:0]           pwm_in,
  input  logic [N_CH-1:0]           chan_en,
  input  logic                      result_ready,
  output logic                      result_valid,
  output logic [ch_w(N_CH)-1:0]     result_ch,
  output logic [CNT_W-1:0]          result_high,
  output logic [CNT_W-1:0]          result_period,
  output logic                      result_timeout,
  output logic                      result_level,
  output logic [ch_w(N_CH)-1:0]     sel_ch,
  output logic                      busy,
  output logic [2*N_CH-1:0]         ch_status
);

  localparam int unsigned CH_W = ch_w(N_CH);
  localparam int unsigned ST_W = $clog2(SETTLE);

  logic [N_CH-1:0]  w_sync, w_rise, w_fall;
  logic             w_sel_sync, w_sel_rise, w_sel_fall, w_tmo;
  logic [CH_W-1:0]  w_lowest_ch, w_next_ch;

  logic [2:0]       r_state;
  logic [CH_W-1:0]  r_sel_ch;
  logic [ST_W-1:0]  r_settle;
  logic [CNT_W-1:0] r_timer, r_high, r_period;
  logic             r_timeout, r_level;

  // Every channel keeps its synchronizer running so a switch never sees stale metastable data.
  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    pwm_sync_edge u_sync (
      .i_clk   (CLK100MHZ),
      .i_reset (reset),
      .i_d     (pwm_in[g]),
      .o_sync  (w_sync[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign w_sel_sync = w_sync[r_sel_ch];
  assign w_sel_rise = w_rise[r_sel_ch];
  assign w_sel_fall = w_fall[r_sel_ch];
  assign w_tmo      = (r_timer == CNT_W'(TIMEOUT - 1));

  // Lowest enabled channel, and first enabled channel after r_sel_ch (itself last).
  always_comb begin
    int idx;
    idx         = 0;
    w_lowest_ch = '0;
    w_next_ch   = r_sel_ch;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (chan_en[CH_W'(i)]) w_lowest_ch = CH_W'(i);
    end
    for (int k = int'(N_CH); k >= 1; k--) begin
      idx = (int'(r_sel_ch) + k) % int'(N_CH);
      if (chan_en[CH_W'(idx)]) w_next_ch = CH_W'(idx);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sel_ch  <= '0;
      r_settle  <= '0;
      r_timer   <= '0;
      r_high    <= '0;
      r_period  <= '0;
      r_timeout <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|chan_en) begin
            r_sel_ch <= w_lowest_ch;
            r_settle <= '0;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == ST_W'(SETTLE - 1)) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
            r_level   <= 1'b0;
            r_state   <= ST_WAIT_RISE;
          end else begin
            r_settle <= r_settle + ST_W'(1);
          end
        end
        ST_WAIT_RISE, ST_MEAS_HIGH, ST_MEAS_LOW: begin
          r_timer <= r_timer + CNT_W'(1);
          // A timeout takes priority over any edge seen in the same cycle.
          if (w_tmo) begin
            r_timeout <= 1'b1;
            r_level   <= w_sel_sync;
            r_high    <= '0;
            r_period  <= '0;
            r_state   <= ST_REPORT;
          end else if (r_state == ST_WAIT_RISE) begin
            if (w_sel_rise) begin
              r_high   <= CNT_W'(1);
              r_period <= CNT_W'(1);
              r_state  <= ST_MEAS_HIGH;
            end
          end else if (r_state == ST_MEAS_HIGH) begin
            r_period <= r_period + CNT_W'(1);
            if (w_sel_fall) r_state <= ST_MEAS_LOW;
            else            r_high  <= r_high + CNT_W'(1);
          end else begin
            if (w_sel_rise) r_state  <= ST_REPORT;
            else            r_period <= r_period + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          if (result_ready) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (|chan_en) begin
            r_sel_ch <= w_next_ch;
            r_settle <= '0;
            r_state  <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result_valid   = (r_state == ST_REPORT);
  assign result_ch      = r_sel_ch;
  assign result_high    = r_high;
  assign result_period  = r_period;
  assign result_timeout = r_timeout;
  assign result_level   = r_level;
  assign sel_ch         = r_sel_ch;
  assign busy           = (r_state != ST_IDLE);

`ifdef PWM_MEAS_STATUS_EN
  logic [2*N_CH-1:0] r_status;
  logic [N_CH-1:0]   w_ch_oh;

  assign w_ch_oh = N_CH'(1) << r_sel_ch;

  // Upper half: stuck flags, lower half: alive flags; each accept clears the opposite flag.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_status <= '0;
    end else if (result_valid && result_ready) begin
      if (r_timeout) begin
        r_status <= {r_status[2*N_CH-1:N_CH] | w_ch_oh, r_status[N_CH-1:0] & ~w_ch_oh};
      end else begin
        r_status <= {r_status[2*N_CH-1:N_CH] & ~w_ch_oh, r_status[N_CH-1:0] | w_ch_oh};
      end
    end
  end

  assign ch_status = r_status;
`else
  assign ch_status = '0;
`endif

endmodule

// File: tb/tb_pwm_meas_scheduler.sv
// Self-checking bench: timestamp-based reference model of the scheduler plus directed scenarios.
module tb_pwm_meas_scheduler;

  localparam int NC  = 8;
  localparam int TMO = 1000;
  localparam int STL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pwm_in;
  logic [7:0]  chan_en;
  logic        result_ready;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [23:0] result_high;
  logic [23:0] result_period;
  logic        result_timeout;
  logic        result_level;
  logic [2:0]  sel_ch;
  logic        busy;
  logic [15:0] ch_status;

  always #5 clk = ~clk;

  pwm_meas_scheduler #(
    .N_CH    (NC),
    .CNT_W   (24),
    .TIMEOUT (TMO),
    .SETTLE  (STL)
  ) dut (
    .CLK100MHZ      (clk),
    .reset          (reset),
    .pwm_in         (pwm_in),
    .chan_en        (chan_en),
    .result_ready   (result_ready),
    .result_valid   (result_valid),
    .result_ch      (result_ch),
    .result_high    (result_high),
    .result_period  (result_period),
    .result_timeout (result_timeout),
    .result_level   (result_level),
    .sel_ch         (sel_ch),
    .busy           (busy),
    .ch_status      (ch_status)
  );

  typedef struct {
    int ch;
    int high;
    int period;
    int tmo;
    int level;
  } rec_t;

  rec_t got[$];
  int   per[NC], hi[NC], ph[NC];
  bit   rdy_rand;
  int   rdy_pct;
  int   total, bad, n;

  // Reference model: edge timestamps on the synchronized view of the selected channel.
  int          m_mode;  // 0 idle, 1 settling/measuring, 2 reporting, 3 choosing next
  logic [2:0]  m_ch;
  int          m_start, m_r1, m_f, m_high, m_period, m_tmo, m_level;
  logic [15:0] m_status;
  logic [7:0]  h0, h1, h2, h3;  // hK = pwm_in sampled K edges ago

  function automatic logic wv(int c, int t);
    return ((t + ph[c]) % per[c]) < hi[c];
  endfunction

  function automatic logic [2:0] lowest(logic [7:0] en);
    for (int i = 0; i < NC; i++) if (en[3'(i)]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [2:0] next_after(logic [2:0] cur, logic [7:0] en);
    int idx;
    for (int k = 1; k <= NC; k++) begin
      idx = (int'(cur) + k) % NC;
      if (en[3'(idx)]) return 3'(idx);
    end
    return cur;
  endfunction

  task automatic begin_meas();
    m_mode  = 1;
    m_start = n + STL + 1;
    m_r1    = -1;
    m_f     = -1;
  endtask

  task automatic report(int tmo, int lvl, int hv, int pv);
    m_mode   = 2;
    m_tmo    = tmo;
    m_level  = lvl;
    m_high   = hv;
    m_period = pv;
  endtask

  task automatic model_edge();
    logic s, d;
    h3 = h2; h2 = h1; h1 = h0; h0 = pwm_in;
    if (reset) begin
      m_mode = 0; m_ch = 3'd0; m_status = '0;
      h0 = '0; h1 = '0; h2 = '0; h3 = '0;
      return;
    end
    case (m_mode)
      0: if (chan_en != 8'h00) begin m_ch = lowest(chan_en); begin_meas(); end
      1: if (n >= m_start) begin
        s = h2[m_ch];
        d = h3[m_ch];
        if (n - m_start == TMO - 1)  report(1, int'(s), 0, 0);
        else if (m_r1 < 0)         begin if (s && !d) m_r1 = n; end
        else if (m_f < 0)          begin if (!s && d) m_f = n; end
        else if (s && !d)          report(0, 0, m_f - m_r1, n - m_r1);
      end
      2: if (result_ready) begin
`ifdef PWM_MEAS_STATUS_EN
        m_status[m_ch]      = (m_tmo == 0);
        m_status[NC + m_ch] = (m_tmo != 0);
`endif
        m_mode = 3;
      end
      3: if (chan_en == 8'h00) m_mode = 0;
         else begin m_ch = next_after(m_ch, chan_en); begin_meas(); end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", nm, n - 1, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bounded wait expired at edge %0d, got no event want one", nm, n);
  endtask

  task automatic compare();
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("valid", 32'(result_valid), 32'(m_mode == 2));
    chk("sel_ch", 32'(sel_ch), 32'(m_ch));
    chk("ch_status", 32'(ch_status), 32'(m_status));
    if (m_mode == 2) begin
      chk("res_ch", 32'(result_ch), 32'(m_ch));
      chk("res_high", 32'(result_high), 32'(m_high));
      chk("res_period", 32'(result_period), 32'(m_period));
      chk("res_timeout", 32'(result_timeout), 32'(m_tmo));
      chk("res_level", 32'(result_level), 32'(m_level));
    end
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk);
    if (rdy_rand) result_ready = ($urandom_range(99) < rdy_pct);
    for (int c = 0; c < NC; c++) pwm_in[c] = wv(c, n);
    if (result_valid && result_ready) begin
      r.ch = int'(result_ch); r.high = int'(result_high); r.period = int'(result_period);
      r.tmo = int'(result_timeout); r.level = int'(result_level);
      got.push_back(r);
    end
    @(posedge clk);
    model_edge();
    n++;
    #1;
    compare();
  endtask

  task automatic set_all(int p, int h);
    for (int c = 0; c < NC; c++) begin
      per[c] = p; hi[c] = h; ph[c] = $urandom_range(p - 1);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_records(int cnt, int budget, string nm);
    int i;
    for (i = 0; i < budget && got.size() < cnt; i++) step();
    if (got.size() < cnt) expire(nm);
  endtask

  initial begin
    int seq[6];
    int i;
    seq = '{0, 2, 5, 7, 0, 2};
    total = 0; bad = 0; n = 0;
    m_mode = 0; m_ch = 3'd0; m_status = '0;
    m_start = 0; m_r1 = -1; m_f = -1; m_high = 0; m_period = 0; m_tmo = 0; m_level = 0;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    rdy_rand = 1'b0; rdy_pct = 100;
    reset = 1'b1; chan_en = 8'h00; result_ready = 1'b1; pwm_in = 8'h00;
    set_all(1, 0);
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_sel", 32'(sel_ch), 32'd0);

    // Single channel, period 100 / high 25.
    per[3] = 100; hi[3] = 25; ph[3] = $urandom_range(99);
    chan_en = 8'h08; reset = 1'b0; got.delete();
    wait_records(1, 300, "t1_first_record");
    wait_records(2, 300, "t1_second_record");
    for (int k = 0; k < 2; k++) if (got.size() > k) begin
      chk("t1_ch", 32'(got[k].ch), 32'd3);
      chk("t1_high", 32'(got[k].high), 32'd25);
      chk("t1_period", 32'(got[k].period), 32'd100);
      chk("t1_tmo", 32'(got[k].tmo), 32'd0);
    end

    // Stuck-high channel 0 must time out.
    pulse_reset();
    per[0] = 1; hi[0] = 1; ph[0] = 0;
    chan_en = 8'h01; got.delete();
    for (i = 1; i <= 1200 && got.size() == 0; i++) step();
    if (got.size() == 0) expire("t2_timeout_record");
    else begin
      chk("t2_latency", 32'(i - 1), 32'd1006);
      chk("t2_ch", 32'(got[0].ch), 32'd0);
      chk("t2_tmo", 32'(got[0].tmo), 32'd1);
      chk("t2_level", 32'(got[0].level), 32'd1);
      chk("t2_high", 32'(got[0].high), 32'd0);
      chk("t2_period", 32'(got[0].period), 32'd0);
    end

    // Round robin over 0,2,5,7.
    pulse_reset();
    set_all(40, 10);
    chan_en = 8'hA5; got.delete();
    wait_records(6, 3000, "t3_records");
    for (int k = 0; k < 6; k++) if (got.size() > k) begin
      chk("t3_seq_ch", 32'(got[k].ch), 32'(seq[k]));
      chk("t3_high", 32'(got[k].high), 32'd10);
      chk("t3_period", 32'(got[k].period), 32'd40);
    end

    // Backpressure: hold a record for 50 cycles.
    result_ready = 1'b0;
    for (i = 0; i < 400 && !result_valid; i++) step();
    if (!result_valid) expire("t4_report");
    else begin
      repeat (50) step();
      chk("t4_valid_held", 32'(result_valid), 32'd1);
      chk("t4_high_held", 32'(result_high), 32'd10);
      chk("t4_period_held", 32'(result_period), 32'd40);
      result_ready = 1'b1;
      step();
      chk("t4_accepted", 32'(result_valid), 32'd0);
      chk("t4_next_busy", 32'(busy), 32'd1);
    end

    // Reset in the middle of the high phase.
    per[3] = 100; hi[3] = 50; ph[3] = $urandom_range(99);
    pulse_reset();
    chan_en = 8'h08;
    for (i = 0; i < 400 && !(m_mode == 1 && m_r1 >= 0 && m_f < 0); i++) step();
    if (!(m_mode == 1 && m_r1 >= 0 && m_f < 0)) expire("t5_reach_high");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(result_valid), 32'd0);
    chk("t5_sel", 32'(sel_ch), 32'd0);
    got.delete();
    wait_records(1, 400, "t5_restart_record");
    if (got.size() > 0) begin
      chk("t5_ch", 32'(got[0].ch), 32'd3);
      chk("t5_high", 32'(got[0].high), 32'd50);
      chk("t5_period", 32'(got[0].period), 32'd100);
    end

    // Empty mask stays idle, then a single channel starts.
    pulse_reset();
    set_all(40, 10);
    chan_en = 8'h00; got.delete();
    repeat (5000) step();
    chk("t6_no_record", 32'(got.size()), 32'd0);
    chan_en = 8'h40;
    step();
    chk("t6_sel", 32'(sel_ch), 32'd6);
    chk("t6_busy", 32'(busy), 32'd1);

    // Randomized waveforms, masks and ready.
    rdy_rand = 1'b1; rdy_pct = 70;
    for (int blk = 0; blk < 5; blk++) begin
      for (int c = 0; c < NC; c++) begin
        per[c] = $urandom_range(150, 8);
        case ($urandom_range(9))
          0:       hi[c] = 0;
          1:       hi[c] = per[c];
          default: hi[c] = $urandom_range(per[c] - 1, 1);
        endcase
        ph[c] = $urandom_range(per[c] - 1);
      end
      chan_en = 8'($urandom_range(255, 1));
      repeat (1500) step();
      chan_en = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      repeat (1500) step();
    end
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
